harris_event_sink: RTL and testbench

- Consumer end of the sobel3 gradient-event interface. Drives `ready_for_new_event` back to the gradient stage.
- Buffers incoming gradient events (xx, yy, xy, addr) in a FIFO and computes the Harris response R = det − k·trace².
- Emits only corner events (R > threshold) on a valid/ready output toward the downstream corner-list writer.

---
 rtl/harris_pkg.sv | 24 ++
 rtl/grad_event_fifo.sv | 36 +++
 rtl/harris_event_sink.sv | 110 +++++++++++
 tb/tb_harris_event_sink.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/harris_pkg.sv
// harris_pkg: shared widths, Harris k defaults and event types for the Harris event sink.
package harris_pkg;
  localparam int DATA_WIDTH_DEF = 4;
  localparam int K_NUM_DEF = 3;
  localparam int K_SHIFT_DEF = 6;
  function automatic int gw_of(input int dw);
    return 2 * (dw + 3);
  endfunction
  function automatic int rw_of(input int dw);
    return 2 * gw_of(dw) + 3;
  endfunction
  localparam int GW_DEF = gw_of(DATA_WIDTH_DEF);
  localparam int RW_DEF = rw_of(DATA_WIDTH_DEF);
  typedef struct packed {
    logic [GW_DEF-1:0]      xx;
    logic [GW_DEF-1:0]      yy;
    logic signed [GW_DEF:0] xy;
    logic [15:0]            addr;
  } grad_event_t;
  typedef struct packed {
    logic [15:0]              addr;
    logic signed [RW_DEF-1:0] score;
  } corner_event_t;
endpackage

// File: rtl/grad_event_fifo.sv
// grad_event_fifo: synchronous FIFO of gradient events with show-ahead head and free-slot count.
module grad_event_fifo
  import harris_pkg::*;
#(
  parameter type T = grad_event_t,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  T                         din,
  input  logic                     pop,
  output T                         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  T mem [DEPTH];
  // Pointers carry one extra bit so full and empty differ only in the wrap MSB.
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign free = (AW+1)'(DEPTH) - (wp - rp);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/harris_event_sink.sv
// harris_event_sink: buffers gradient events, computes R = det - k*trace^2, emits corners (R > THRESHOLD).
// Optional HARRIS_STATS_EN adds saturating event/corner/drop counters.
module harris_event_sink
  import harris_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int GW = gw_of(DATA_WIDTH),
  parameter int RW = 2 * GW + 3,
  parameter int FIFO_DEPTH = 16,
  parameter int READY_MARGIN = 2,
  parameter int K_NUM = K_NUM_DEF,
  parameter int K_SHIFT = K_SHIFT_DEF,
  parameter logic signed [RW-1:0] THRESHOLD = RW'(1000)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [GW-1:0]        gradient_xx,
  input  logic [GW-1:0]        gradient_yy,
  input  logic signed [GW:0]   gradient_xy,
  input  logic [15:0]          in_event_addr,
  input  logic                 in_event_valid,
  output logic                 ready_for_new_event,
  output logic                 out_corner_valid,
  output logic [15:0]          out_corner_addr,
  output logic signed [RW-1:0] out_corner_score,
  input  logic                 out_ready,
  output logic                 overflow
`ifdef HARRIS_STATS_EN
  ,
  output logic [31:0]          stat_events,
  output logic [31:0]          stat_corners,
  output logic [15:0]          stat_dropped
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = 2 * GW + 2 + $clog2(K_NUM + 1);
  typedef struct packed {
    logic [GW-1:0]      xx;
    logic [GW-1:0]      yy;
    logic signed [GW:0] xy;
    logic [15:0]        addr;
  } ev_t;
  ev_t din, head;
  logic full, empty, push, pop, adv, corner, v1, v2;
  logic [AW:0] free;
  logic [AW+1:0] free_next;
  logic [2*GW-1:0] p_xx_yy;
  logic [2*GW+1:0] p_xy2;
  logic [GW:0] tr;
  logic [15:0] a1, a2;
  logic signed [RW-1:0] det, r2;
  assign din = {gradient_xx, gradient_yy, gradient_xy, in_event_addr};
  assign adv = !out_corner_valid || out_ready;
  assign pop = adv && !empty;
  assign push = in_event_valid && (!full || pop);
  assign free_next = (AW+2)'(free) + (AW+2)'(pop) - (AW+2)'(push);
  assign det = $signed(RW'(p_xx_yy)) - $signed(RW'(p_xy2));
  assign corner = v2 && (r2 > THRESHOLD);
  grad_event_fifo #(.T(ev_t), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(din), .pop(pop),
    .dout(head), .full(full), .empty(empty), .free(free)
  );
  always_ff @(posedge clk)
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (adv) begin
      v1 <= pop;
      v2 <= v1;
      p_xx_yy <= (2*GW)'(head.xx) * (2*GW)'(head.yy);
      p_xy2 <= $unsigned((2*GW+2)'(head.xy) * (2*GW+2)'(head.xy));
      tr <= (GW+1)'(head.xx) + (GW+1)'(head.yy);
      a1 <= head.addr;
      // tr^2*k is non-negative, so a logical shift truncates like >>>.
      r2 <= det - $signed(RW'((TW'(tr) * TW'(tr) * TW'(K_NUM)) >> K_SHIFT));
      a2 <= a1;
    end
  always_ff @(posedge clk)
    if (rst) begin
      out_corner_valid <= 1'b0;
      out_corner_addr <= '0;
      out_corner_score <= '0;
    end else if (adv) begin
      out_corner_valid <= corner;
      if (corner) begin
        out_corner_addr <= a2;
        out_corner_score <= r2;
      end
    end
  always_ff @(posedge clk)
    if (rst) begin
      ready_for_new_event <= 1'b0;
      overflow <= 1'b0;
    end else begin
      ready_for_new_event <= free_next > (AW+2)'(READY_MARGIN);
      if (in_event_valid && !push) overflow <= 1'b1;
    end
`ifdef HARRIS_STATS_EN
  always_ff @(posedge clk)
    if (rst) begin
      stat_events <= '0;
      stat_corners <= '0;
      stat_dropped <= '0;
    end else begin
      if (push && !(&stat_events)) stat_events <= stat_events + 1'b1;
      if (out_corner_valid && out_ready && !(&stat_corners)) stat_corners <= stat_corners + 1'b1;
      if (in_event_valid && !push && !(&stat_dropped)) stat_dropped <= stat_dropped + 1'b1;
    end
`endif
endmodule

// File: tb/tb_harris_event_sink.sv
// tb_harris_event_sink: scoreboard bench; stimulus pushes expected corners, a monitor checks each handshake.
module tb_harris_event_sink;
  localparam int GW = 14;
  localparam int RW = 31;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [GW-1:0] xx = '0, yy = '0;
  logic signed [GW:0] xy = '0;
  logic [15:0] addr_in = '0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic ready_for_new_event, out_corner_valid, overflow;
  logic [15:0] out_corner_addr;
  logic signed [RW-1:0] out_corner_score;
`ifdef HARRIS_STATS_EN
  logic [31:0] stat_events, stat_corners;
  logic [15:0] stat_dropped;
`endif
  typedef struct packed {
    logic [15:0] addr;
    logic signed [RW-1:0] score;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int total = 0, bad = 0, sent = 0;

  always #5 clk = ~clk;

  harris_event_sink dut (
    .clk(clk), .rst(rst),
    .gradient_xx(xx), .gradient_yy(yy), .gradient_xy(xy),
    .in_event_addr(addr_in), .in_event_valid(in_valid),
    .ready_for_new_event(ready_for_new_event),
    .out_corner_valid(out_corner_valid), .out_corner_addr(out_corner_addr),
    .out_corner_score(out_corner_score), .out_ready(out_ready),
    .overflow(overflow)
`ifdef HARRIS_STATS_EN
    , .stat_events(stat_events), .stat_corners(stat_corners), .stat_dropped(stat_dropped)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int x, input int y, input int v, input int a);
    xx = GW'(x);
    yy = GW'(y);
    xy = (GW+1)'(v);
    addr_in = 16'(a);
    in_valid = 1'b1;
  endtask

  task automatic expect_corner(input int a, input int s);
    exp_t e;
    e.addr = 16'(a);
    e.score = RW'(s);
    sb.push_back(e);
  endtask

  task automatic send(input int x, input int y, input int v, input int a, input bit is_corner, input int s);
    drive(x, y, v, a);
    if (is_corner) expect_corner(a, s);
    step();
    in_valid = 1'b0;
  endtask

  // Handshake completes at the next posedge; inputs only change just after posedges.
  always @(negedge clk)
    if (!rst && out_corner_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_corner: got addr=%h score=%0d expected none", out_corner_addr, out_corner_score);
      end else begin
        mon_e = sb.pop_front();
        check("corner_addr", 64'(out_corner_addr), 64'(mon_e.addr));
        check("corner_score", 64'(out_corner_score), 64'(mon_e.score));
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    check("rst_ready", 64'(ready_for_new_event), 0);
    check("rst_valid", 64'(out_corner_valid), 0);
    check("rst_addr", 64'(out_corner_addr), 0);
    check("rst_score", 64'(out_corner_score), 0);
    check("rst_overflow", 64'(overflow), 0);
    rst = 1'b0;
    step();
    check("ready_after_reset", 64'(ready_for_new_event), 1);

    // Single corner: R = 10000 - 1875, visible 4 cycles after in_event_valid.
    out_ready = 1'b1;
    send(100, 100, 0, 16'h0A0B, 1'b1, 8125);
    step();
    step();
    check("latency_early", 64'(out_corner_valid), 0);
    step();
    check("latency_4", 64'(out_corner_valid), 1);
    step();

    // Rejections (R=-468, -1875, 0, 1000) and the first score above threshold (1001).
    send(100, 0, 0, 16'h0001, 1'b0, 0);
    send(100, 100, 100, 16'h0002, 1'b0, 0);
    send(0, 0, 0, 16'h0003, 1'b0, 0);
    send(34, 38, -7, 16'h0100, 1'b0, 0);
    send(32, 40, -6, 16'h0101, 1'b1, 1001);
    repeat (8) step();
    check("drain_basic", 64'(sb.size()), 0);

    // Backpressure honouring ready: 3 in pipeline + 14 in FIFO before ready falls.
    out_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 40; c++) begin
      if (ready_for_new_event && sent < 20) begin
        drive(100, 100, 0, 16'h2000 + sent);
        expect_corner(16'h2000 + sent, 8125);
        sent++;
      end else in_valid = 1'b0;
      step();
    end
    in_valid = 1'b0;
    check("bp_sent_stalled", 64'(sent), 17);
    check("bp_ready_low", 64'(ready_for_new_event), 0);
    check("bp_no_overflow", 64'(overflow), 0);
    out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (ready_for_new_event && sent < 20) begin
        drive(100, 100, 0, 16'h2000 + sent);
        expect_corner(16'h2000 + sent, 8125);
        sent++;
      end else in_valid = 1'b0;
      step();
    end
    in_valid = 1'b0;
    check("bp_sent_all", 64'(sent), 20);
    repeat (30) step();
    check("bp_drained", 64'(sb.size()), 0);
    check("bp_overflow_clear", 64'(overflow), 0);

    // Overflow: 19 retained (out, S2, S1, 16 in FIFO), the 20th dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(100, 100, 0, 16'h3000 + i);
      if (i < 19) expect_corner(16'h3000 + i, 8125);
      step();
    end
    in_valid = 1'b0;
    step();
    check("ovf_flag", 64'(overflow), 1);
    check("ovf_ready_low", 64'(ready_for_new_event), 0);
    check("ovf_out_valid", 64'(out_corner_valid), 1);
`ifdef HARRIS_STATS_EN
    check("stat_dropped", 64'(stat_dropped), 1);
    check("stat_events", 64'(stat_events), 45);
`endif
    out_ready = 1'b1;
    repeat (40) step();
    check("ovf_drained", 64'(sb.size()), 0);
    check("ovf_sticky", 64'(overflow), 1);

    // Reset mid-stream with buffered events and a pending corner.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(100, 100, 0, 16'h4000 + i);
      step();
    end
    in_valid = 1'b0;
    check("pre_rst_valid", 64'(out_corner_valid), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_valid", 64'(out_corner_valid), 0);
    check("midrst_ready", 64'(ready_for_new_event), 0);
    check("midrst_overflow", 64'(overflow), 0);
    step();
    check("midrst_ready_rise", 64'(ready_for_new_event), 1);
    out_ready = 1'b1;
    repeat (15) step();
    send(100, 100, 0, 16'h5555, 1'b1, 8125);
    repeat (8) step();
    check("final_drained", 64'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
